axi_slave_mem: RTL and testbench

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_slave_mem_if.sv | 61 ++++++
 rtl/axi_addr_gen.sv | 41 ++++
 rtl/axi_slave_mem.sv | 261 ++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI types for the slave memory: burst encodings, response
// codes and the write/read channel state enums.
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

endpackage

// File: rtl/axi_slave_mem_if.sv
// AXI write/read channel bundle between a master and the slave memory.
// Ports: AW, W, B, AR, R channel signals; master and slave modports.
interface axi_slave_mem_if;

    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_addr_gen.sv
// Next-beat address and burst legality for one AXI address channel.
// Ports: addr/len/size/burst in; next_addr, legal out.
module axi_addr_gen
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [7:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr,
    output logic        legal
);

    logic [31:0] step;
    logic [31:0] span;
    logic [31:0] mask;
    logic [31:0] incr;

    always_comb begin
        step = 32'd1 << size;
        span = ({24'd0, len} + 32'd1) << size;
        mask = span - 32'd1;
        incr = addr + step;

        legal = (size <= 3'd2) && (burst != 2'b11);
        if (burst == WRAP) begin
            legal = legal && (len == 8'd1 || len == 8'd3 ||
                              len == 8'd7 || len == 8'd15);
        end

        // WRAP keeps the bits above the block boundary and lets the
        // low bits roll over inside the block.
        case (burst)
            FIXED:   next_addr = addr;
            INCR:    next_addr = incr;
            WRAP:    next_addr = (addr & ~mask) | (incr & mask);
            default: next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI memory slave: independent write and read burst engines over a
// word array. Ports: clk, rst_n (async, active low), bus (slave modport).
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int          MEM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst_n,
    axi_slave_mem_if.slave bus
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [31:0] mem [MEM_DEPTH];

    function automatic logic hit(input logic [31:0] a);
        return (a >= BASE_ADDR) &&
               (((a - BASE_ADDR) >> 2) < 32'(MEM_DEPTH));
    endfunction

    function automatic logic [AW-1:0] widx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    // Holds the ready outputs low until the first edge after reset.
    logic live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else        live <= 1'b1;
    end

    // ---------------- write channel ----------------
    wstate_e     wstate, wstate_nx;
    logic [31:0] wcur;
    logic [7:0]  wlen, wcnt;
    logic [2:0]  wsize;
    logic [1:0]  wburst;
    logic        wsup, werr;

    logic [31:0] wg_addr, wg_next;
    logic [7:0]  wg_len;
    logic [2:0]  wg_size;
    logic [1:0]  wg_burst;
    logic        wg_legal;

    logic aw_hs, w_hs, b_hs, w_final, w_bad, w_we;

    // While idle the generator judges the incoming request; afterwards it
    // steps the captured burst.
    always_comb begin
        if (wstate == W_IDLE) begin
            wg_addr  = bus.awaddr;
            wg_len   = bus.awlen;
            wg_size  = bus.awsize;
            wg_burst = bus.awburst;
        end else begin
            wg_addr  = wcur;
            wg_len   = wlen;
            wg_size  = wsize;
            wg_burst = wburst;
        end
    end

    axi_addr_gen u_wgen (
        .addr      (wg_addr),
        .len       (wg_len),
        .size      (wg_size),
        .burst     (wg_burst),
        .next_addr (wg_next),
        .legal     (wg_legal)
    );

    assign aw_hs   = bus.awvalid & bus.awready;
    assign w_hs    = bus.wvalid & bus.wready;
    assign b_hs    = bus.bvalid & bus.bready;
    assign w_final = (wcnt == wlen);
    assign w_bad   = !hit(wcur) || (bus.wlast != w_final);
    assign w_we    = w_hs && !wsup && hit(wcur);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wstate <= W_IDLE;
        else        wstate <= wstate_nx;
    end

    always_comb begin
        wstate_nx   = wstate;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        unique case (wstate)
            W_IDLE: begin
                bus.awready = live;
                if (bus.awvalid && live) wstate_nx = W_DATA;
            end
            W_DATA: begin
                bus.wready = 1'b1;
                if (bus.wvalid && w_final) wstate_nx = W_RESP;
            end
            W_RESP: begin
                bus.bvalid = 1'b1;
                if (bus.bready) wstate_nx = W_IDLE;
            end
            default: wstate_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcur      <= '0;
            wlen      <= '0;
            wsize     <= '0;
            wburst    <= '0;
            wcnt      <= '0;
            wsup      <= 1'b0;
            werr      <= 1'b0;
            bus.bresp <= OKAY;
        end else begin
            if (aw_hs) begin
                wcur   <= bus.awaddr;
                wlen   <= bus.awlen;
                wsize  <= bus.awsize;
                wburst <= bus.awburst;
                wcnt   <= '0;
                wsup   <= !wg_legal;
                werr   <= !wg_legal;
            end
            if (w_hs) begin
                werr <= werr | w_bad;
                if (w_final) begin
                    bus.bresp <= (werr | w_bad) ? SLVERR : OKAY;
                end else begin
                    wcnt <= wcnt + 8'd1;
                    wcur <= wg_next;
                end
            end
            if (b_hs) bus.bresp <= OKAY;
        end
    end

    // Storage is never reset so a reset keeps its contents.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) begin
                    mem[widx(wcur)][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // ---------------- read channel ----------------
    rstate_e     rstate, rstate_nx;
    logic [31:0] rcur;
    logic [7:0]  rlen, rcnt;
    logic [2:0]  rsize;
    logic [1:0]  rburst;

    logic [31:0] rg_addr, rg_next;
    logic [7:0]  rg_len;
    logic [2:0]  rg_size;
    logic [1:0]  rg_burst;
    logic        rg_legal;

    logic        ar_hs, r_hs, rd_ok;
    logic [31:0] rd_addr, rd_word;

    always_comb begin
        if (rstate == R_IDLE) begin
            rg_addr  = bus.araddr;
            rg_len   = bus.arlen;
            rg_size  = bus.arsize;
            rg_burst = bus.arburst;
        end else begin
            rg_addr  = rcur;
            rg_len   = rlen;
            rg_size  = rsize;
            rg_burst = rburst;
        end
    end

    axi_addr_gen u_rgen (
        .addr      (rg_addr),
        .len       (rg_len),
        .size      (rg_size),
        .burst     (rg_burst),
        .next_addr (rg_next),
        .legal     (rg_legal)
    );

    assign ar_hs = bus.arvalid & bus.arready;
    assign r_hs  = bus.rvalid & bus.rready;

    // The beat being loaded: the request address on AR, else the
    // successor of the beat now on the bus. The array is read before
    // this edge's write lands, which gives read-first behaviour.
    always_comb begin
        rd_addr = (rstate == R_IDLE) ? bus.araddr : rg_next;
        rd_ok   = rg_legal && hit(rd_addr);
        rd_word = rd_ok ? mem[widx(rd_addr)] : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rstate <= R_IDLE;
        else        rstate <= rstate_nx;
    end

    always_comb begin
        rstate_nx   = rstate;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        unique case (rstate)
            R_IDLE: begin
                bus.arready = live;
                if (bus.arvalid && live) rstate_nx = R_DATA;
            end
            R_DATA: begin
                bus.rvalid = 1'b1;
                if (bus.rready && bus.rlast) rstate_nx = R_IDLE;
            end
            default: rstate_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcur      <= '0;
            rlen      <= '0;
            rsize     <= '0;
            rburst    <= '0;
            rcnt      <= '0;
            bus.rdata <= '0;
            bus.rresp <= OKAY;
            bus.rlast <= 1'b0;
        end else if (ar_hs) begin
            rcur      <= bus.araddr;
            rlen      <= bus.arlen;
            rsize     <= bus.arsize;
            rburst    <= bus.arburst;
            rcnt      <= '0;
            bus.rdata <= rd_word;
            bus.rresp <= rd_ok ? OKAY : SLVERR;
            bus.rlast <= (bus.arlen == 8'd0);
        end else if (r_hs) begin
            if (bus.rlast) begin
                bus.rdata <= '0;
                bus.rresp <= OKAY;
                bus.rlast <= 1'b0;
            end else begin
                rcur      <= rg_next;
                rcnt      <= rcnt + 8'd1;
                bus.rdata <= rd_word;
                bus.rresp <= rd_ok ? OKAY : SLVERR;
                bus.rlast <= ((rcnt + 8'd1) == rlen);
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: expected R beats and B responses
// are queued at issue and compared as the slave presents them.
module tb_axi_slave_mem;

    localparam int DEPTH = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    axi_slave_mem_if bus ();

    axi_slave_mem #(
        .MEM_DEPTH (DEPTH),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t      rq[$];
    logic [1:0]  bq[$];
    logic [31:0] mdl [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    int checks = 0;
    int errors = 0;
    bit rr_toggle = 1'b0;
    bit rr_hold   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit legal_b(input logic [7:0] len,
                                   input logic [2:0] size,
                                   input logic [1:0] burst);
        if (size > 3'd2 || burst == 2'b11) return 1'b0;
        if (burst == 2'b10)
            return len == 1 || len == 3 || len == 7 || len == 15;
        return 1'b1;
    endfunction

    function automatic logic [31:0] nxt(input logic [31:0] a,
                                        input logic [7:0] len,
                                        input logic [2:0] size,
                                        input logic [1:0] burst);
        int unsigned step, blk, base;
        step = 32'd1 << size;
        blk  = (int'(len) + 1) * step;
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            base = a - (a % blk);
            return base + ((a - base + step) % blk);
        end
        return a + step;
    endfunction

    function automatic bit inr(input logic [31:0] a);
        return (a >> 2) < DEPTH;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.rvalid) begin
            if (rq.size() == 0) begin
                chk("r_extra", 32'(bus.rvalid), 32'd0);
            end else begin
                chk("rdata", bus.rdata, rq[0].data);
                chk("rresp", 32'(bus.rresp), 32'(rq[0].resp));
                chk("rlast", 32'(bus.rlast), 32'(rq[0].last));
                if (bus.rready) void'(rq.pop_front());
            end
        end
        if (rst_n && bus.bvalid) begin
            if (bq.size() == 0) begin
                chk("b_extra", 32'(bus.bvalid), 32'd0);
            end else begin
                chk("bresp", 32'(bus.bresp), 32'(bq[0]));
                if (bus.bready) void'(bq.pop_front());
            end
        end
    end

    initial begin
        bus.rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rr_hold)        bus.rready = 1'b0;
            else if (rr_toggle) bus.rready = ~bus.rready;
            else                bus.rready = 1'b1;
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input bit bad_last);
        logic [31:0] a;
        logic [31:0] w;
        bit lg;
        bit err;
        int n;
        lg  = legal_b(len, size, burst);
        err = !lg || bad_last;
        a   = addr;
        for (int i = 0; i <= int'(len); i++) begin
            if (!inr(a)) err = 1'b1;
            a = nxt(a, len, size, burst);
        end
        bq.push_back(err ? 2'b10 : 2'b00);
        bus.awaddr  = addr;
        bus.awlen   = len;
        bus.awsize  = size;
        bus.awburst = burst;
        bus.awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.awready && n < 100) begin @(negedge clk); n++; end
        if (!bus.awready) chk("aw_to", 32'(bus.awready), 32'd1);
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wdata  = wd[i];
            bus.wstrb  = ws[i];
            bus.wlast  = (i == int'(len)) ^ bad_last;
            bus.wvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!bus.wready && n < 100) begin @(negedge clk); n++; end
            if (!bus.wready) chk("w_to", 32'(bus.wready), 32'd1);
            if (lg && inr(a)) begin
                w = mdl[a[11:2]];
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
                mdl[a[11:2]] = w;
            end
            @(posedge clk);
            #1;
            a = nxt(a, len, size, burst);
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        n = 0;
        while (bq.size() != 0 && n < 100) begin @(negedge clk); n++; end
        if (bq.size() != 0) chk("b_to", 32'(bq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read_issue(input logic [31:0] addr, input logic [7:0] len,
                                  input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        rbeat_t e;
        bit lg;
        int n;
        lg = legal_b(len, size, burst);
        a  = addr;
        for (int i = 0; i <= int'(len); i++) begin
            e.last = (i == int'(len));
            if (lg && inr(a)) begin
                e.data = mdl[a[11:2]];
                e.resp = 2'b00;
            end else begin
                e.data = 32'd0;
                e.resp = 2'b10;
            end
            rq.push_back(e);
            a = nxt(a, len, size, burst);
        end
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.arready && n < 100) begin @(negedge clk); n++; end
        if (!bus.arready) chk("ar_to", 32'(bus.arready), 32'd1);
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        chk("r_lat", 32'(bus.rvalid), 32'd1);
    endtask

    task automatic axi_read_drain();
        int n;
        n = 0;
        while (rq.size() != 0 && n < 600) begin @(negedge clk); n++; end
        if (rq.size() != 0) chk("r_to", 32'(rq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        axi_read_issue(addr, len, size, burst);
        axi_read_drain();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"},
            32'({bus.awready, bus.wready, bus.bvalid, bus.bresp,
                 bus.arready, bus.rvalid, bus.rresp, bus.rlast}), 32'd0);
        chk({tag, "_rdata"}, bus.rdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arvalid = 1'b0;

        // reset state and first edge after release
        repeat (2) @(posedge clk);
        #2;
        chk_quiet("rst");
        #2 rst_n = 1'b1;
        #1 chk("rel_aw", 32'(bus.awready), 32'd0);
        @(posedge clk);
        #1;
        chk("up_aw", 32'(bus.awready), 32'd1);
        chk("up_ar", 32'(bus.arready), 32'd1);

        // INCR write/readback
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
        axi_write(32'h10, 8'd3, 3'd2, 2'b01, 1'b0);
        axi_read(32'h10, 8'd3, 3'd2, 2'b01);

        // WRAP read across the block boundary
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + i; ws[i] = 4'hF; end
        axi_write(32'h00, 8'd3, 3'd2, 2'b01, 1'b0);
        axi_read(32'h0C, 8'd3, 3'd2, 2'b10);

        // partial strobes
        wd[0] = 32'h1122_3344; ws[0] = 4'hF;
        axi_write(32'h40, 8'd0, 3'd2, 2'b01, 1'b0);
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'b0101;
        axi_write(32'h40, 8'd0, 3'd2, 2'b01, 1'b0);
        axi_read(32'h40, 8'd0, 3'd2, 2'b01);

        // same-cycle write and read of one word returns the old value
        bq.push_back(2'b00);
        bus.awaddr = 32'h40; bus.awlen = 8'd0; bus.awsize = 3'd2;
        bus.awburst = 2'b01; bus.awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.awready && n < 100) begin @(negedge clk); n++; end
        if (!bus.awready) chk("aw_to", 32'(bus.awready), 32'd1);
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        rq.push_back('{data: mdl[16], resp: 2'b00, last: 1'b1});
        bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wlast = 1'b1;
        bus.wvalid = 1'b1;
        bus.araddr = 32'h40; bus.arlen = 8'd0; bus.arsize = 3'd2;
        bus.arburst = 2'b01; bus.arvalid = 1'b1;
        @(negedge clk);
        chk("rf_hs", 32'({bus.wready, bus.arready}), 32'd3);
        @(posedge clk);
        #1;
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.arvalid = 1'b0;
        mdl[16] = 32'hCAFE_F00D;
        axi_read_drain();
        axi_read(32'h40, 8'd0, 3'd2, 2'b01);

        // out of range read and write; word 0 must not be aliased
        axi_read(32'(DEPTH * 4), 8'd0, 3'd2, 2'b01);
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        axi_write(32'(DEPTH * 4), 8'd0, 3'd2, 2'b01, 1'b0);
        axi_read(32'h00, 8'd0, 3'd2, 2'b01);

        // FIXED and illegal bursts
        axi_read(32'h10, 8'd2, 3'd2, 2'b00);
        axi_read(32'h10, 8'd1, 3'd2, 2'b11);
        wd[0] = 32'h55; ws[0] = 4'hF;
        axi_write(32'h80, 8'd0, 3'd2, 2'b01, 1'b0);
        wd[0] = 32'h66;
        axi_write(32'h80, 8'd0, 3'd3, 2'b01, 1'b0);
        axi_read(32'h80, 8'd0, 3'd2, 2'b01);
        for (int i = 0; i < 3; i++) begin wd[i] = 32'h300 + i; ws[i] = 4'hF; end
        axi_write(32'h300, 8'd2, 3'd2, 2'b10, 1'b0);
        axi_write(32'h100, 8'd1, 3'd2, 2'b01, 1'b1);

        // backpressure with concurrent bursts
        for (int i = 0; i < 8; i++) begin wd[i] = 32'h7000_0000 + i; ws[i] = 4'hF; end
        bus.bready = 1'b0;
        rr_toggle  = 1'b1;
        fork
            axi_write(32'h140, 8'd7, 3'd2, 2'b01, 1'b0);
            begin
                n = 0;
                while (!bus.bvalid && n < 200) begin @(negedge clk); n++; end
                repeat (5) @(posedge clk);
                #1 bus.bready = 1'b1;
            end
            axi_read(32'h10, 8'd3, 3'd2, 2'b01);
        join
        rr_toggle = 1'b0;
        axi_read(32'h140, 8'd7, 3'd2, 2'b01);

        // reset in the middle of a write and a stalled read
        rr_hold = 1'b1;
        @(posedge clk);
        #2;
        axi_read_issue(32'h10, 8'd3, 3'd2, 2'b01);
        bus.awaddr = 32'h200; bus.awlen = 8'd3; bus.awsize = 3'd2;
        bus.awburst = 2'b01; bus.awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.awready && n < 100) begin @(negedge clk); n++; end
        if (!bus.awready) chk("aw_to", 32'(bus.awready), 32'd1);
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wdata = 32'hC0 + i; bus.wstrb = 4'hF; bus.wlast = 1'b0;
            bus.wvalid = 1'b1;
            if (i == 2) break;
            n = 0;
            @(negedge clk);
            while (!bus.wready && n < 100) begin @(negedge clk); n++; end
            if (!bus.wready) chk("w_to", 32'(bus.wready), 32'd1);
            mdl[128 + i] = 32'hC0 + i;
            @(posedge clk);
            #1;
        end
        #1 rst_n = 1'b0;
        #1 chk_quiet("mid");
        rq.delete();
        bq.delete();
        bus.wvalid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk("rel2_aw", 32'(bus.awready), 32'd0);
        @(posedge clk);
        #1;
        chk("up2_aw", 32'(bus.awready), 32'd1);
        chk("up2_ar", 32'(bus.arready), 32'd1);
        rr_hold = 1'b0;
        @(posedge clk);
        #2;
        axi_read(32'h200, 8'd1, 3'd2, 2'b01);
        axi_read(32'h10, 8'd0, 3'd2, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
